// File: rtl/gray_to_binary_converter_serial_if.sv
// Handshake bundle for the serial Gray-to-binary decoder: Gray input channel, binary
// result channel and the busy flag.
interface gray_to_binary_converter_serial_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] Gray_Data_In;
  logic             Gray_Valid_In;
  logic             Gray_Ready_Out;
  logic             Binary_Valid_Out;
  logic             Binary_Ready_In;
  logic             Busy_Out;

  modport master (
    output Gray_Data_In,
    output Gray_Valid_In,
    output Binary_Ready_In,
    input  Gray_Ready_Out,
    input  Binary_Valid_Out,
    input  Busy_Out
  );

  modport slave (
    input  Gray_Data_In,
    input  Gray_Valid_In,
    input  Binary_Ready_In,
    output Gray_Ready_Out,
    output Binary_Valid_Out,
    output Busy_Out
  );
endinterface

// File: rtl/gray_to_binary_converter_serial.sv
// Multi-cycle Gray-to-binary decoder: resolves one binary bit per enabled clock, MSB
// first, between an input and an output valid/ready handshake.
module gray_to_binary_converter_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                              Clock_In,
  input  logic                              Reset_In,
  input  logic                              Enable_In,
  gray_to_binary_converter_serial_if.slave  bus,
  output wire  [WIDTH-1:0]                  Binary_Data_Out
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_q;
  logic [IDX_W-1:0] idx_q;

  // Disabled cycles freeze every register, so re-enabling resumes mid-conversion.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      gray_q  <= '0;
      bin_q   <= '0;
      idx_q   <= '0;
    end else if (Enable_In) begin
      case (state_q)
        IDLE: begin
          if (bus.Gray_Valid_In) begin
            gray_q  <= bus.Gray_Data_In;
            bin_q   <= bus.Gray_Data_In & MSB_MASK;
            idx_q   <= IDX_W'(WIDTH - 2);
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bin_q[idx_q] <= bin_q[IDX_W'(idx_q + IDX_W'(1))] ^ gray_q[idx_q];
          if (idx_q == '0) begin
            state_q <= DONE;
          end else begin
            idx_q <= IDX_W'(idx_q - IDX_W'(1));
          end
        end
        DONE: begin
          if (bus.Binary_Ready_In) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags are gated by Enable_In so no transfer completes while frozen.
  assign bus.Gray_Ready_Out   = Enable_In && (state_q == IDLE);
  assign bus.Binary_Valid_Out = Enable_In && (state_q == DONE);
  assign bus.Busy_Out         = (state_q != IDLE);
  assign Binary_Data_Out      = Enable_In ? bin_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_gray_to_binary_converter_serial.sv
// Bench for the serial Gray-to-binary decoder: a cycle-level transaction model plus
// directed scenarios (latency, exhaustive decode, backpressure, reset, enable freeze).
module tb_gray_to_binary_converter_serial;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  wire  [W-1:0] bdo;
  int           checks   = 0;
  int           failures = 0;
  int           cyc_cnt  = 0;

  gray_to_binary_converter_serial_if #(.WIDTH(W)) bus ();

  gray_to_binary_converter_serial #(.WIDTH(W)) dut (
    .Clock_In        (clk),
    .Reset_In        (rst),
    .Enable_In       (en),
    .bus             (bus),
    .Binary_Data_Out (bdo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < int'(W); k++) b ^= (g >> k);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: a word is accepted, spends W-1 enabled cycles resolving, then
  // waits for the consumer.
  bit           m_busy;
  int           m_rem;
  logic [W-1:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_rem  <= 0;
      m_res  <= '0;
    end else if (en) begin
      if (!m_busy) begin
        if (bus.Gray_Valid_In) begin
          m_busy <= 1'b1;
          m_rem  <= int'(W) - 1;
          m_res  <= g2b(bus.Gray_Data_In);
        end
      end else if (m_rem != 0) begin
        m_rem <= m_rem - 1;
      end else if (bus.Binary_Ready_In) begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("mdl_ready", 32'(bus.Gray_Ready_Out), 32'(en && !m_busy));
      check("mdl_valid", 32'(bus.Binary_Valid_Out), 32'(en && m_busy && m_rem == 0));
      check("mdl_busy", 32'(bus.Busy_Out), 32'(m_busy));
      if (en && m_busy && m_rem == 0) check("mdl_data", 32'(bdo), 32'(m_res));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, presents one word for a single edge, then counts edges until valid.
  task automatic send_wait(input logic [W-1:0] g, output int lat, output int acc_t);
    int n;
    n = 0;
    while (!bus.Gray_Ready_Out && n < 40) begin
      tick();
      n++;
    end
    check("ready_before_send", 32'(bus.Gray_Ready_Out), 32'd1);
    bus.Gray_Data_In  = g;
    bus.Gray_Valid_In = 1'b1;
    tick();
    bus.Gray_Valid_In = 1'b0;
    acc_t = cyc_cnt;
    lat = 0;
    while (!bus.Binary_Valid_Out && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int lat;
    int acc_t;
    int prev_t;
    int n;
    bit seen;
    logic [W-1:0] gg;

    rst = 1'b1;
    en  = 1'b1;
    bus.Gray_Data_In    = '0;
    bus.Gray_Valid_In   = 1'b0;
    bus.Binary_Ready_In = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(bus.Gray_Ready_Out), 32'd1);
    check("rst_valid", 32'(bus.Binary_Valid_Out), 32'd0);
    check("rst_busy", 32'(bus.Busy_Out), 32'd0);
    check("rst_data", 32'(bdo), 32'h00);

    // Single word, latency and return to idle.
    send_wait(8'hC4, lat, acc_t);
    check("lat_c4", 32'(lat), 32'd7);
    check("data_c4", 32'(bdo), 32'h87);
    tick();
    check("idle_after_c4_busy", 32'(bus.Busy_Out), 32'd0);
    check("idle_after_c4_ready", 32'(bus.Gray_Ready_Out), 32'd1);

    // Every 8-bit value round-trips through binary-to-gray and back at 9 cycles/word.
    prev_t = 0;
    for (int b = 0; b < 256; b++) begin
      gg = W'(b ^ (b >> 1));
      send_wait(gg, lat, acc_t);
      if (b > 0) check("interval", 32'(acc_t - prev_t), 32'd9);
      prev_t = acc_t;
      check("exh_data", 32'(bdo), 32'(b));
    end
    tick();

    // Backpressure in DONE: result held, new input refused until after the handshake.
    bus.Binary_Ready_In = 1'b0;
    send_wait(8'hC4, lat, acc_t);
    check("bp_lat", 32'(lat), 32'd7);
    bus.Gray_Data_In  = 8'h3C;
    bus.Gray_Valid_In = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data", 32'(bdo), 32'h87);
      check("bp_ready", 32'(bus.Gray_Ready_Out), 32'd0);
      check("bp_valid", 32'(bus.Binary_Valid_Out), 32'd1);
    end
    bus.Binary_Ready_In = 1'b1;
    tick();
    check("bp_release_busy", 32'(bus.Busy_Out), 32'd0);
    tick();
    bus.Gray_Valid_In = 1'b0;
    check("bp_next_accepted", 32'(bus.Busy_Out), 32'd1);
    n = 0;
    while (!bus.Binary_Valid_Out && n < 40) begin
      tick();
      n++;
    end
    check("bp_next_data", 32'(bdo), 32'h28);
    tick();

    // Reset three cycles after acceptance aborts the word.
    bus.Gray_Data_In  = 8'hC4;
    bus.Gray_Valid_In = 1'b1;
    tick();
    bus.Gray_Valid_In = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.Busy_Out), 32'd0);
    check("abort_ready", 32'(bus.Gray_Ready_Out), 32'd1);
    check("abort_valid", 32'(bus.Binary_Valid_Out), 32'd0);
    check("abort_data", 32'(bdo), 32'h00);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.Binary_Valid_Out) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    // Enable held low for 4 cycles mid-conversion delays the result by exactly 4.
    bus.Gray_Data_In  = 8'hC4;
    bus.Gray_Valid_In = 1'b1;
    tick();
    bus.Gray_Valid_In = 1'b0;
    lat = 0;
    repeat (2) begin
      tick();
      lat++;
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      lat++;
      check("frz_busy", 32'(bus.Busy_Out), 32'd1);
      check("frz_ready", 32'(bus.Gray_Ready_Out), 32'd0);
      check("frz_valid", 32'(bus.Binary_Valid_Out), 32'd0);
    end
    en = 1'b1;
    while (!bus.Binary_Valid_Out && lat < 40) begin
      tick();
      lat++;
    end
    check("frz_lat", 32'(lat), 32'd11);
    check("frz_data", 32'(bdo), 32'h87);
    tick();

    // Random traffic, enable drops and backpressure, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      bus.Gray_Valid_In   = 1'($urandom_range(0, 1));
      bus.Gray_Data_In    = W'($urandom);
      bus.Binary_Ready_In = ($urandom_range(0, 9) < 6);
      en                  = ($urandom_range(0, 9) != 0);
      tick();
    end
    en = 1'b1;
    bus.Gray_Valid_In   = 1'b0;
    bus.Binary_Ready_In = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
